// File: rtl/mem_access_unit.sv
// mem_access_unit: turns a CPU word load/store into four big-endian byte beats
// on a narrow memory port, with alignment/range checking and an ack timeout.
module mem_access_unit #(
  parameter int MEM_BYTES   = 64,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, CHECK, BEAT, FIN} state_t;

  localparam int unsigned   WCW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [31:0]   MAX_ADDR  = 32'(MEM_BYTES - 4);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(ACK_TIMEOUT - 1);

  state_t          state;
  logic            lat_we;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic [1:0]      byte_idx;
  logic [WCW-1:0]  wait_cnt;
  logic [31:0]     shadow;

  logic [1:0]      next_idx;
  logic            bad_addr;
  logic [31:0]     load_word;

  // Big-endian lane select: beat 0 carries the most significant byte.
  function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // Next beat index, address legality, and the completed load word (last byte bypasses shadow).
  always_comb begin
    next_idx  = byte_idx + 2'd1;
    bad_addr  = (lat_addr[1:0] != 2'b00) || (lat_addr > MAX_ADDR);
    load_word = {shadow[31:8], mem_rdata};
  end

  // Access FSM; all outputs registered so the memory bus is glitch-free.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      byte_idx  <= '0;
      wait_cnt  <= '0;
      shadow    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (bad_addr) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= FIN;
          end else begin
            byte_idx  <= '0;
            wait_cnt  <= '0;
            mem_req   <= 1'b1;
            mem_we    <= lat_we;
            mem_addr  <= lat_addr;
            mem_wdata <= lat_we ? lane(lat_wdata, 2'd0) : 8'h00;
            state     <= BEAT;
          end
        end
        BEAT: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            if (!lat_we) begin
              case (byte_idx)
                2'd0:    shadow[31:24] <= mem_rdata;
                2'd1:    shadow[23:16] <= mem_rdata;
                2'd2:    shadow[15:8]  <= mem_rdata;
                default: shadow[7:0]   <= mem_rdata;
              endcase
            end
            if (byte_idx == 2'd3) begin
              if (!lat_we) rdata <= load_word;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              done      <= 1'b1;
              err       <= 1'b0;
              state     <= FIN;
            end else begin
              byte_idx  <= next_idx;
              mem_addr  <= lat_addr + {30'b0, next_idx};
              mem_wdata <= lat_we ? lane(lat_wdata, next_idx) : 8'h00;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt  <= wait_cnt + 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b1;
            err       <= 1'b1;
            state     <= FIN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FIN: begin
          done     <= 1'b0;
          err      <= 1'b0;
          busy     <= 1'b0;
          byte_idx <= '0;
          wait_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, wait states, bad
// addresses, ack timeout, mid-access reset and back-to-back requests.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  // Memory model: mode 0 = ack tied high, 1 = two wait cycles per beat, 2 = ack stuck low.
  int          mode = 0;
  int          wcnt = 0;
  logic [31:0] rom_word = 32'hAABBCCDD;

  // Beat log and bus monitors.
  logic [31:0] ba_q[$];
  logic [7:0]  bd_q[$];
  logic        bw_q[$];
  int          req_cycles = 0;
  int          idle_bus_bad = 0;
  int          rdata_bad = 0;
  int          done_cnt = 0;
  logic [31:0] prev_rdata = '0;

  int   lat;
  logic e;

  mem_access_unit #(.MEM_BYTES(64), .ACK_TIMEOUT(16)) dut (
    .CLK(CLK), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    case (mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = mem_req && (wcnt == 2);
      default: mem_ack = 1'b0;
    endcase
    case (mem_addr[1:0])
      2'd0:    mem_rdata = rom_word[31:24];
      2'd1:    mem_rdata = rom_word[23:16];
      2'd2:    mem_rdata = rom_word[15:8];
      default: mem_rdata = rom_word[7:0];
    endcase
  end

  always @(posedge CLK) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (Reset) begin
        if (mem_req) req_cycles++;
        if (mem_req && mem_ack) begin
          ba_q.push_back(mem_addr);
          bd_q.push_back(mem_wdata);
          bw_q.push_back(mem_we);
        end
        if (!mem_req && (mem_we || mem_addr != 0 || mem_wdata != 0)) idle_bus_bad++;
        if (done) done_cnt++;
        if (rdata != prev_rdata && !done) rdata_bad++;
      end
      prev_rdata = rdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    ba_q.delete();
    bd_q.delete();
    bw_q.delete();
    req_cycles = 0;
  endtask

  // One access; lat = cycles from the req edge to the done cycle (0 if never seen).
  task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output int l, output logic ee);
    clear_log();
    @(posedge CLK); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge CLK); #1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    l = 0; ee = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge CLK);
      if (done) begin
        l = n; ee = err;
        break;
      end
    end
  endtask

  initial begin
    Reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #12;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_mem_req", {31'b0, mem_req}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", rdata, 0);
    @(negedge CLK); Reset = 1'b1;

    // Store, zero-wait memory.
    mode = 0; rom_word = 32'h5A5A5A5A;
    run_access(1'b1, 32'h8, 32'h11223344, lat, e);
    check("st_lat", 32'(lat), 6);
    check("st_err", {31'b0, e}, 0);
    check("st_nbeats", 32'(ba_q.size()), 4);
    for (int k = 0; k < 4 && k < ba_q.size(); k++) begin
      check($sformatf("st_addr%0d", k), ba_q[k], 32'(8 + k));
      check($sformatf("st_we%0d", k), {31'b0, bw_q[k]}, 1);
    end
    if (bd_q.size() == 4)
      check("st_bytes", {bd_q[0], bd_q[1], bd_q[2], bd_q[3]}, 32'h11223344);
    check("st_rdata", rdata, 0);

    // Load with two wait cycles per beat.
    mode = 1; rom_word = 32'hAABBCCDD;
    run_access(1'b0, 32'h10, 32'h0, lat, e);
    check("ld_lat", 32'(lat), 14);
    check("ld_err", {31'b0, e}, 0);
    check("ld_rdata", rdata, 32'hAABBCCDD);
    check("ld_req_cycles", 32'(req_cycles), 12);
    check("ld_nbeats", 32'(ba_q.size()), 4);
    for (int k = 0; k < 4 && k < ba_q.size(); k++) begin
      check($sformatf("ld_addr%0d", k), ba_q[k], 32'(16 + k));
      check($sformatf("ld_we%0d", k), {31'b0, bw_q[k]}, 0);
    end

    // Misaligned and out-of-range addresses.
    mode = 0; rom_word = 32'h12345678;
    run_access(1'b0, 32'h6, 32'h0, lat, e);
    check("mis_lat", 32'(lat), 2);
    check("mis_err", {31'b0, e}, 1);
    check("mis_req_cycles", 32'(req_cycles), 0);
    run_access(1'b1, 32'h40, 32'hFFFFFFFF, lat, e);
    check("oor_lat", 32'(lat), 2);
    check("oor_err", {31'b0, e}, 1);
    check("oor_req_cycles", 32'(req_cycles), 0);
    check("bad_rdata", rdata, 32'hAABBCCDD);

    // Highest legal word address.
    rom_word = 32'h99887766;
    run_access(1'b1, 32'h3C, 32'hCAFEBABE, lat, e);
    check("top_lat", 32'(lat), 6);
    check("top_err", {31'b0, e}, 0);
    check("top_nbeats", 32'(ba_q.size()), 4);
    if (ba_q.size() == 4) check("top_last_addr", ba_q[3], 32'h3F);
    check("top_rdata", rdata, 32'hAABBCCDD);

    // Ack stuck low: timeout.
    mode = 2; rom_word = 32'h55667788;
    run_access(1'b0, 32'h14, 32'h0, lat, e);
    check("to_lat", 32'(lat), 18);
    check("to_err", {31'b0, e}, 1);
    check("to_req_cycles", 32'(req_cycles), 16);
    check("to_rdata", rdata, 32'hAABBCCDD);

    // Reset during the third beat of a store.
    mode = 0;
    clear_log();
    @(posedge CLK); #1;
    req = 1'b1; we = 1'b1; addr = 32'h18; wdata = 32'hDEADBEEF;
    @(posedge CLK); #1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (4) @(negedge CLK);
    check("mr_pre_addr", mem_addr, 32'h1A);
    #2 Reset = 1'b0;
    #1;
    check("mr_mem_req", {31'b0, mem_req}, 0);
    check("mr_busy", {31'b0, busy}, 0);
    check("mr_mem_addr", mem_addr, 0);
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    check("mr_idle_busy", {31'b0, busy}, 0);

    // Load after reset.
    mode = 1; rom_word = 32'hCAFEF00D;
    run_access(1'b0, 32'h20, 32'h0, lat, e);
    check("pr_lat", 32'(lat), 14);
    check("pr_err", {31'b0, e}, 0);
    check("pr_rdata", rdata, 32'hCAFEF00D);

    // req held high across two accesses.
    mode = 0; rom_word = 32'h01020304;
    clear_log();
    @(posedge CLK); #1;
    req = 1'b1; we = 1'b0; addr = 32'h0;
    @(posedge CLK); #1;
    addr = 32'h4;
    repeat (6) @(negedge CLK);
    check("b2b_done1", {31'b0, done}, 1);
    check("b2b_err1", {31'b0, err}, 0);
    check("b2b_rdata1", rdata, 32'h01020304);
    @(negedge CLK);
    check("b2b_idle_busy", {31'b0, busy}, 0);
    @(posedge CLK); #1;
    req = 1'b0; addr = '0;
    @(negedge CLK);
    check("b2b_check_busy", {31'b0, busy}, 1);
    check("b2b_check_memreq", {31'b0, mem_req}, 0);
    repeat (5) @(negedge CLK);
    check("b2b_done2", {31'b0, done}, 1);
    check("b2b_nbeats", 32'(ba_q.size()), 8);
    if (ba_q.size() == 8) begin
      check("b2b_addr4", ba_q[4], 32'h4);
      check("b2b_addr7", ba_q[7], 32'h7);
    end
    repeat (2) @(negedge CLK);

    check("bus_idle_zero", 32'(idle_bus_bad), 0);
    check("rdata_stable", 32'(rdata_bad), 0);
    check("done_pulses", 32'(done_cnt), 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
